// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the EX-stage ALU shift units.
//   state_e  : sequencer states for the multi-cycle shifters
//   DATA_W   : datapath width (32)
//   SHAMT_W  : shift-amount width (5)
//   flags_t  : flag vector, packed as {C,V,N,Z} (C is the MSB)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The same ordering is used by every shift unit in the ALU.
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

endpackage : alu_pkg

// File: rtl/sll_step.sv
// ---------------------------------------------------------------------------
// sll_step
// Combinational logical left shift by 0..STEP positions with zero fill.
// Parameters:
//   STEP  : largest shift this block has to perform in one call
//   K_W   : width of the shift-distance input
// Ports:
//   data_in   in  DATA_W  word to shift
//   k         in  K_W     shift distance (values above STEP are clamped)
//   data_out  out DATA_W  shifted word
//   carry_out out 1       last bit shifted out (data_in[DATA_W-k]), 0 if k=0
// ---------------------------------------------------------------------------
module sll_step
  import alu_pkg::*;
#(
  parameter int STEP = 1,
  parameter int K_W  = 4
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] data_out,
  output logic              carry_out
);

  logic [K_W-1:0]  k_eff;
  logic [DATA_W:0] wide;

  // Clamp so the hardware never shifts more than STEP positions.
  assign k_eff = (k > K_W'(STEP)) ? K_W'(STEP) : k;

  // A one-bit guard above the word catches the last bit pushed out of the
  // top; with k=0 the guard stays zero, which is the desired carry.
  assign wide      = {1'b0, data_in} << k_eff;
  assign data_out  = wide[DATA_W-1:0];
  assign carry_out = wide[DATA_W];

endmodule : sll_step

// File: rtl/shift_left_logical_seq.sv
// ---------------------------------------------------------------------------
// shift_left_logical_seq
// Multi-cycle logical left shifter (SLL/SLLV) for the EX stage. An operand
// and a shift amount are captured on start; the accumulator is shifted
// STEP positions per cycle; result and {C,V,N,Z} flags are registered on
// entry to DONE, where done pulses for one cycle. busy covers SHIFT and DONE
// so the hazard unit can stall the pipeline.
//
// Parameters:
//   STEP     : bit positions per cycle, one of 1, 2, 4, 8
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   T        in   32-bit operand
//   shamt    in   5-bit shift amount
//   abort    in   pipeline flush (only when SLL_SEQ_ABORT_EN is defined)
//   Y_lo     out  shifted result
//   C,V,N,Z  out  carry / overflow / negative / zero flags
//   busy     out  high in SHIFT and DONE
//   done     out  one-cycle completion pulse
//
// Build option: define SLL_SEQ_ABORT_EN to add the abort port.
// ---------------------------------------------------------------------------
module shift_left_logical_seq
  import alu_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  T,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SLL_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [DATA_W-1:0]  Y_lo,
  output logic               C,
  output logic               V,
  output logic               N,
  output logic               Z,
  output logic               busy,
  output logic               done
);

  localparam int K_W = 4;

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
      $error("shift_left_logical_seq: STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               carry_q, carry_d;
  logic               sign_q, sign_d;
  logic [DATA_W-1:0]  y_q, y_d;
  flags_t             flags_q, flags_d;
  logic               done_q, done_d;

  logic               abort_w;
  logic [K_W-1:0]     step_k;
  logic [DATA_W-1:0]  step_data;
  logic               step_carry;

`ifdef SLL_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // k = min(STEP, remaining). When remaining < STEP it is below 8 and fits
  // in the low bits.
  assign step_k = (rem_q < SHAMT_W'(STEP)) ? rem_q[K_W-1:0] : K_W'(STEP);

  sll_step #(
    .STEP (STEP),
    .K_W  (K_W)
  ) u_sll_step (
    .data_in   (acc_q),
    .k         (step_k),
    .data_out  (step_data),
    .carry_out (step_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    y_d     = y_q;
    flags_d = flags_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = T;
          rem_d   = shamt;
          sign_d  = T[DATA_W-1];
          carry_d = 1'b0;          // shamt=0 must report C=0
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (rem_q == '0) begin
          // Results become visible together with done.
          state_d   = DONE;
          y_d       = acc_q;
          flags_d.c = carry_q;
          flags_d.v = acc_q[DATA_W-1] ^ sign_q;
          flags_d.n = acc_q[DATA_W-1];
          flags_d.z = (acc_q == '0);
          done_d    = 1'b1;
        end else begin
          acc_d   = step_data;
          carry_d = step_carry;
          rem_d   = rem_q - SHAMT_W'(step_k);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      y_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  assign Y_lo = y_q;
  assign C    = flags_q.c;
  assign V    = flags_q.v;
  assign N    = flags_q.n;
  assign Z    = flags_q.z;
  assign busy = (state_q != IDLE);
  // A flush during the DONE cycle suppresses the completion pulse.
  assign done = done_q & ~abort_w;

endmodule : shift_left_logical_seq

// File: tb/tb_shift_left_logical_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_left_logical_seq
// Randomised and directed bench for shift_left_logical_seq (STEP=4).
// Expected results come from plain 64-bit arithmetic on T and shamt.
// ---------------------------------------------------------------------------
module tb_shift_left_logical_seq;

  localparam int STEP = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] t_in;
  logic [4:0]  shamt_in;
  logic [31:0] y_lo;
  logic        c_flag, v_flag, n_flag, z_flag;
  logic        busy, done;
`ifdef SLL_SEQ_ABORT_EN
  logic        abort_in;
  initial abort_in = 1'b0;
`endif

  int tests_run;
  int tests_failed;

  shift_left_logical_seq #(
    .STEP (STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .T       (t_in),
    .shamt   (shamt_in),
`ifdef SLL_SEQ_ABORT_EN
    .abort   (abort_in),
`endif
    .Y_lo    (y_lo),
    .C       (c_flag),
    .V       (v_flag),
    .N       (n_flag),
    .Z       (z_flag),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [4:0] sh);
    return (int'(sh) + STEP - 1) / STEP + 2;
  endfunction

  // One operation. Called at a falling edge with the DUT idle. mid_cycle>0
  // pulses a second (ignored) start during that cycle of the operation.
  task automatic run_op(input logic [31:0] t_val, input logic [4:0] sh,
                        input int mid_cycle);
    logic [63:0] wide;
    logic [31:0] ey;
    logic [3:0]  ef;
    logic [31:0] prev_y;
    logic [31:0] y_at_done;
    logic [3:0]  f_at_done;
    int          lat, done_cnt, first_done, busy_cnt;

    wide = {32'b0, t_val} << sh;
    ey   = wide[31:0];
    ef   = {wide[32], ey[31] ^ t_val[31], ey[31], (ey == 32'b0)};
    lat  = latency(sh);
    done_cnt = 0; first_done = 0; busy_cnt = 0;
    y_at_done = 32'hx; f_at_done = 4'hx;
    prev_y = y_lo;

    start = 1'b1; t_in = t_val; shamt_in = sh;
    @(negedge clk);
    start = 1'b0; t_in = ~t_val; shamt_in = ~sh;   // capture must hold

    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      if (cyc == 1) check_val("y_hold_before_done", y_lo, prev_y);
      if (done) begin
        done_cnt++;
        if (first_done == 0) first_done = cyc;
        y_at_done = y_lo;
        f_at_done = {c_flag, v_flag, n_flag, z_flag};
      end
      if (busy) busy_cnt++;
      start = (cyc == mid_cycle);
      if (cyc == mid_cycle) begin
        t_in = $urandom; shamt_in = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
    end
    start = 1'b0;

    check_val("done_cycle", first_done, lat);
    check_val("done_count", done_cnt, 1);
    check_val("busy_cycles", busy_cnt, lat);
    check_val("y_lo", y_at_done, ey);
    check_val("flags_cvnz", {28'b0, f_at_done}, {28'b0, ef});
    check_val("y_lo_held", y_lo, ey);
    check_val("busy_after", {31'b0, busy}, 32'd0);
    $display("[TB] op T=%h shamt=%0d mid=%0d -> Y=%h CVNZ=%b done@%0d exp Y=%h CVNZ=%b done@%0d",
             t_val, sh, mid_cycle, y_at_done, f_at_done, first_done, ey, ef, lat);
  endtask

  initial begin
    int rsh, rlat, rmid, done_seen;

    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; start = 1'b0; t_in = '0; shamt_in = '0;
    repeat (2) @(negedge clk);
    check_val("rst_y_lo", y_lo, 32'd0);
    check_val("rst_flags", {28'b0, c_flag, v_flag, n_flag, z_flag}, 32'd0);
    check_val("rst_busy_done", {30'b0, busy, done}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases, including shamt boundaries 0 and 31.
    run_op(32'h00000001, 5'd31, 0);
    run_op(32'h80000001, 5'd1,  0);
    run_op(32'hF0000000, 5'd4,  0);
    run_op(32'h12345678, 5'd0,  0);
    run_op(32'hA5A5A5A5, 5'd7,  2);
    run_op(32'hFFFFFFFF, 5'd31, 9);
    run_op(32'h7FFFFFFF, 5'd3,  0);

    // Reset in the middle of a shift abandons it.
    start = 1'b1; t_in = 32'hDEADBEEF; shamt_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("midrst_y_lo", y_lo, 32'd0);
    check_val("midrst_flags", {28'b0, c_flag, v_flag, n_flag, z_flag}, 32'd0);
    check_val("midrst_busy_done", {30'b0, busy, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    check_val("midrst_no_done", done_seen, 0);
    $display("[TB] reset during shift, activity after release=%0d", done_seen);
    run_op(32'h0000ABCD, 5'd16, 0);

    // Randomised operations.
    for (int i = 0; i < 40; i++) begin
      rsh  = $urandom_range(0, 31);
      rlat = latency(5'(rsh));
      rmid = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rlat) : 0;
      run_op($urandom, 5'(rsh), rmid);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_shift_left_logical_seq
